complement_serial: RTL

Multi-mode, chunk-serial complement unit: accepts an N-bit operand over a valid/ready handshake and produces one of four results:
- one's complement
- two's complement
- absolute value
- pass-through

It processes W bits per clock, LSB chunk first, with a registered carry between chunks. This trades latency for a W-bit adder instead of an N-bit one. It sits beside the ALU datapath and serves negate/abs micro-ops that do not need single-cycle results.

---
 rtl/complement_serial.sv | 103 ++++++++++
 1 files changed

// File: rtl/complement_serial.sv
// complement_serial: chunk-serial one's/two's complement, absolute value and pass unit
module complement_serial #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         i_CLK,
  input  logic         i_RST,
  input  logic         i_Valid,
  output logic         o_Ready,
  input  logic [N-1:0] i_A,
  input  logic [1:0]   i_Mode,
  output logic         o_Valid,
  input  logic         i_Ready,
  output logic [N-1:0] o_F,
  output logic         o_Ovf,
  output logic         o_Z
);
  localparam int C  = N / W;
  localparam int KW = C > 1 ? $clog2(C) : 1;
  if (W < 1 || W > N || N % W != 0) begin : g_bad_cfg
    $error("complement_serial: N must be a multiple of W with 1 <= W <= N");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d, res_q, res_d, f_q, f_d;
  logic [1:0]    mode_q, mode_d;
  logic          inv_q, inv_d, carry_q, carry_d, ovf_q, ovf_d, z_q, z_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  chunk;
  logic [W:0]    sum;
  logic          last;
  // next-state: accept operand, add one chunk per RUN cycle, publish result on entry to DONE
  always_comb begin
    chunk = '0;
    for (int i = 0; i < C; i++) if (k_q == KW'(i)) chunk = a_q[i*W +: W];
    sum     = {1'b0, chunk ^ {W{inv_q}}} + {{W{1'b0}}, carry_q};
    last    = k_q == KW'(C - 1);
    state_d = state_q;
    a_d     = a_q;
    mode_d  = mode_q;
    inv_d   = inv_q;
    carry_d = carry_q;
    k_d     = k_q;
    res_d   = res_q;
    f_d     = f_q;
    ovf_d   = ovf_q;
    z_d     = z_q;
    case (state_q)
      IDLE: if (i_Valid) begin
        a_d     = i_A;
        mode_d  = i_Mode;
        inv_d   = i_Mode == 2'b10 ? i_A[N-1] : ~i_Mode[1];
        carry_d = inv_d && i_Mode != 2'b00;
        k_d     = '0;
        state_d = RUN;
      end
      RUN: begin
        for (int i = 0; i < C; i++) if (k_q == KW'(i)) res_d[i*W +: W] = sum[W-1:0];
        carry_d = sum[W];
        k_d     = last ? '0 : k_q + 1'b1;
        if (last) begin
          state_d = DONE;
          f_d     = res_d;
          ovf_d   = (mode_q == 2'b01 || mode_q == 2'b10) && inv_q && a_q[N-1] && res_d[N-1];
          z_d     = res_d == '0;
        end
      end
      DONE: if (i_Ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset discards any operation in flight
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      mode_q  <= '0;
      inv_q   <= 1'b0;
      carry_q <= 1'b0;
      k_q     <= '0;
      res_q   <= '0;
      f_q     <= '0;
      ovf_q   <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      mode_q  <= mode_d;
      inv_q   <= inv_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      res_q   <= res_d;
      f_q     <= f_d;
      ovf_q   <= ovf_d;
      z_q     <= z_d;
    end
  end
  assign o_Ready = state_q == IDLE && !i_RST;
  assign o_Valid = state_q == DONE;
  assign o_F     = f_q;
  assign o_Ovf   = ovf_q;
  assign o_Z     = z_q;
endmodule
